// File: rtl/axis_deadlock_watchdog_pkg.sv
// Shared types and helpers for the AXIS kernel deadlock watchdog.
package axis_wdog_pkg;

    // Watchdog life cycle: settle after reset, watch, confirm a stall, hold the diagnosis.
    typedef enum logic [1:0] {
        WARMUP  = 2'd0,
        MONITOR = 2'd1,
        CONFIRM = 2'd2,
        LOCKED  = 2'd3
    } wdog_state_e;

    // Index width for n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axis_deadlock_watchdog_lsb_prio_enc.sv
// Lowest-set-bit priority encoder; yields 0 for an all-zero input.
module lsb_prio_enc
    import axis_wdog_pkg::*;
#(
    parameter int W     = 2,
    parameter int IDX_W = idx_width(W)
) (
    input  logic [W-1:0]     in_vec,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (in_vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/axis_deadlock_watchdog.sv
// Kernel-wide deadlock watchdog: detects a sustained AXIS stall across all
// instances, latches a diagnosis snapshot and raises a sticky flag plus IRQ.
module axis_deadlock_watchdog
    import axis_wdog_pkg::*;
#(
    parameter int NUM_AXIS       = 2,
    parameter int NUM_INST       = 1,
    parameter int CNT_W          = 16,
    parameter int STARTUP_CYCLES = 10,
    localparam int IDX_W         = idx_width(NUM_AXIS)
) (
    input  logic                kernel_monitor_clock,
    input  logic                kernel_monitor_reset,
    input  logic [NUM_AXIS-1:0] axis_block_sigs,
    input  logic [NUM_INST-1:0] inst_idle_sigs,
    input  logic [NUM_INST-1:0] inst_block_sigs,
    input  logic [CNT_W-1:0]    threshold,
    input  logic                clear,
    output logic                block,
    output logic                deadlock,
    output logic                deadlock_irq,
    output logic [NUM_AXIS-1:0] blocked_mask,
    output logic [NUM_AXIS-1:0] stuck_mask,
    output logic [IDX_W-1:0]    first_blocked_idx,
    output logic [CNT_W-1:0]    stall_cycles
);

    localparam int WARM_LAST = (STARTUP_CYCLES > 0) ? STARTUP_CYCLES - 1 : 0;
    localparam int WARM_W    = idx_width(WARM_LAST + 1);

    wdog_state_e         state_q, state_d;
    logic [WARM_W-1:0]   warm_cnt_q, warm_cnt_d;
    logic [CNT_W-1:0]    stall_q, stall_d;
    logic [IDX_W-1:0]    fbi_q, fbi_d;
    logic [NUM_AXIS-1:0] bmask_q, bmask_d;
    logic [NUM_AXIS-1:0] smask_q, smask_d;
    logic                block_q, block_d;
    logic                dl_q, dl_d;
    logic                irq_q, irq_d;

    logic                raw;
    logic [IDX_W-1:0]    lowest_idx;
    logic [CNT_W-1:0]    eff_thr_m1;

    // Stall counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    // Kernel is stalled when some port waits on the outside and no instance is doing work.
    assign raw = (|axis_block_sigs) & (&(inst_idle_sigs | inst_block_sigs));

    lsb_prio_enc #(
        .W     (NUM_AXIS),
        .IDX_W (IDX_W)
    ) u_first_blocked (
        .in_vec (axis_block_sigs),
        .idx    (lowest_idx)
    );

    // Threshold of 0 behaves as 1, so the lock compare is against max(threshold,1)-1.
    always_comb begin
        eff_thr_m1 = (threshold == '0) ? '0 : threshold - CNT_W'(1);
    end

    // Next-state and next-output logic; clear overrides any lock decision outside WARMUP.
    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        stall_d    = stall_q;
        fbi_d      = fbi_q;
        bmask_d    = bmask_q;
        smask_d    = smask_q;
        dl_d       = dl_q;
        irq_d      = 1'b0;
        block_d    = (state_q != WARMUP) & raw;

        if (state_q == WARMUP) begin
            if (warm_cnt_q == WARM_W'(WARM_LAST)) begin
                state_d = MONITOR;
            end else begin
                warm_cnt_d = warm_cnt_q + WARM_W'(1);
            end
        end else if (clear) begin
            state_d = MONITOR;
            dl_d    = 1'b0;
            bmask_d = '0;
            smask_d = '0;
            stall_d = '0;
        end else begin
            case (state_q)
                MONITOR: begin
                    stall_d = '0;
                    if (raw) begin
                        state_d = CONFIRM;
                        stall_d = CNT_W'(1);
                        fbi_d   = lowest_idx;
                    end
                end
                CONFIRM: begin
                    if (!raw) begin
                        state_d = MONITOR;
                        stall_d = '0;
                    end else if (stall_q >= eff_thr_m1) begin
                        state_d = LOCKED;
                        dl_d    = 1'b1;
                        irq_d   = 1'b1;
                        bmask_d = axis_block_sigs;
                        smask_d = ~axis_block_sigs;
                    end else begin
                        stall_d = sat_inc(stall_q);
                    end
                end
                LOCKED: begin
                    if (raw) begin
                        stall_d = sat_inc(stall_q);
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // State and registered outputs; reset aborts any stall and restarts warmup.
    always_ff @(posedge kernel_monitor_clock or negedge kernel_monitor_reset) begin
        if (!kernel_monitor_reset) begin
            state_q    <= WARMUP;
            warm_cnt_q <= '0;
            stall_q    <= '0;
            fbi_q      <= '0;
            bmask_q    <= '0;
            smask_q    <= '0;
            block_q    <= 1'b0;
            dl_q       <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            warm_cnt_q <= warm_cnt_d;
            stall_q    <= stall_d;
            fbi_q      <= fbi_d;
            bmask_q    <= bmask_d;
            smask_q    <= smask_d;
            block_q    <= block_d;
            dl_q       <= dl_d;
            irq_q      <= irq_d;
        end
    end

    assign block             = block_q;
    assign deadlock          = dl_q;
    assign deadlock_irq      = irq_q;
    assign blocked_mask      = bmask_q;
    assign stuck_mask        = smask_q;
    assign first_blocked_idx = fbi_q;
    assign stall_cycles      = stall_q;

endmodule

// File: tb/tb_axis_deadlock_watchdog.sv
// Directed bench for the AXIS deadlock watchdog with a reference model feeding a scoreboard.
module tb_axis_deadlock_watchdog;

    localparam int STARTUP = 10;

    logic       clk;
    logic       rst_n;
    logic [1:0] ab;
    logic [0:0] idle;
    logic [0:0] iblk;
    logic [3:0] thr;
    logic       clr;

    logic       o_blk, o_dl, o_irq;
    logic [1:0] o_bm, o_sm;
    logic [0:0] o_fbi;
    logic [3:0] o_st;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       blk;
        logic       dl;
        logic       irq;
        logic [1:0] bm;
        logic [1:0] sm;
        logic       fbi;
        logic [3:0] st;
    } exp_t;

    exp_t sb[$];

    // reference model state: 0 warmup, 1 monitor, 2 confirm, 3 locked
    int         m_st;
    int         m_warm;
    logic [3:0] m_stall;
    logic       m_fbi, m_blk, m_dl, m_irq;
    logic [1:0] m_bm, m_sm;

    axis_deadlock_watchdog #(
        .NUM_AXIS       (2),
        .NUM_INST       (1),
        .CNT_W          (4),
        .STARTUP_CYCLES (STARTUP)
    ) dut (
        .kernel_monitor_clock (clk),
        .kernel_monitor_reset (rst_n),
        .axis_block_sigs      (ab),
        .inst_idle_sigs       (idle),
        .inst_block_sigs      (iblk),
        .threshold            (thr),
        .clear                (clr),
        .block                (o_blk),
        .deadlock             (o_dl),
        .deadlock_irq         (o_irq),
        .blocked_mask         (o_bm),
        .stuck_mask           (o_sm),
        .first_blocked_idx    (o_fbi),
        .stall_cycles         (o_st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_warm = 0; m_stall = '0; m_fbi = 1'b0;
        m_blk = 1'b0; m_dl = 1'b0; m_irq = 1'b0; m_bm = '0; m_sm = '0;
    endtask

    task automatic model_clock();
        logic raw;
        int   thr_eff;
        if (!rst_n) begin
            model_reset();
            return;
        end
        raw     = (|ab) && (&(idle | iblk));
        thr_eff = (thr == 0) ? 1 : int'(thr);
        m_blk   = (m_st != 0) && raw;
        m_irq   = 1'b0;
        if (m_st == 0) begin
            if (m_warm == STARTUP - 1) m_st = 1;
            else m_warm++;
        end else if (clr) begin
            m_st = 1; m_dl = 1'b0; m_bm = '0; m_sm = '0; m_stall = '0;
        end else if (m_st == 1) begin
            if (raw) begin
                m_st = 2; m_stall = 4'd1; m_fbi = ab[0] ? 1'b0 : 1'b1;
            end
        end else if (m_st == 2) begin
            if (!raw) begin
                m_st = 1; m_stall = '0;
            end else if (int'(m_stall) >= thr_eff - 1) begin
                m_st = 3; m_dl = 1'b1; m_irq = 1'b1; m_bm = ab; m_sm = ~ab;
            end else if (m_stall != 4'hF) begin
                m_stall++;
            end
        end else begin
            if (raw && m_stall != 4'hF) m_stall++;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.blk = m_blk; e.dl = m_dl; e.irq = m_irq; e.bm = m_bm;
        e.sm = m_sm; e.fbi = m_fbi; e.st = m_stall;
        sb.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL sb_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        chk("block",        32'(o_blk), 32'(e.blk));
        chk("deadlock",     32'(o_dl),  32'(e.dl));
        chk("deadlock_irq", 32'(o_irq), 32'(e.irq));
        chk("blocked_mask", 32'(o_bm),  32'(e.bm));
        chk("stuck_mask",   32'(o_sm),  32'(e.sm));
        chk("first_idx",    32'(o_fbi), 32'(e.fbi));
        chk("stall_cycles", 32'(o_st),  32'(e.st));
    endtask

    // one clock: model advances with the DUT, outputs compared on the falling edge
    task automatic step();
        @(posedge clk);
        model_clock();
        push_exp();
        @(negedge clk);
        check_pop();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst_n = 1'b0; ab = 2'b00; idle = 1'b1; iblk = 1'b0; thr = 4'd4; clr = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        push_exp();
        check_pop();
        chk("rst_deadlock", 32'(o_dl), 32'd0);

        // T1/T2: raw held from release; nothing during warmup, lock at threshold 4
        ab = 2'b10;
        rst_n = 1'b1;
        steps(10);
        chk("t1_block_warmup", 32'(o_blk), 32'd0);
        chk("t1_no_lock_warmup", 32'(o_dl), 32'd0);
        steps(4);
        chk("t2_irq", 32'(o_irq), 32'd1);
        chk("t2_bmask", 32'(o_bm), 32'h2);
        chk("t2_smask", 32'(o_sm), 32'h1);
        chk("t2_first_idx", 32'(o_fbi), 32'd1);
        step();
        chk("t2_irq_pulse", 32'(o_irq), 32'd0);
        chk("t2_sticky", 32'(o_dl), 32'd1);

        // stall counter keeps counting in LOCKED and saturates
        steps(15);
        chk("sat_stall", 32'(o_st), 32'hF);

        // clear from LOCKED
        clr = 1'b1; ab = 2'b00;
        step();
        clr = 1'b0;
        chk("clr_deadlock", 32'(o_dl), 32'd0);

        // T3: raw for 3 cycles then low, no lock
        ab = 2'b01;
        steps(3);
        ab = 2'b00;
        step();
        chk("t3_stall_zero", 32'(o_st), 32'd0);
        chk("t3_no_lock", 32'(o_dl), 32'd0);
        chk("t3_idx_kept", 32'(o_fbi), 32'd0);

        // T4: threshold 0 acts as 1, lock 2 clocks after raw rises
        thr = 4'd0; ab = 2'b11;
        step();
        chk("t4_not_yet", 32'(o_dl), 32'd0);
        step();
        chk("t4_irq", 32'(o_irq), 32'd1);
        clr = 1'b1; ab = 2'b00;
        step();
        clr = 1'b0;

        // a busy instance suppresses raw block
        thr = 4'd4; ab = 2'b11; idle = 1'b0; iblk = 1'b0;
        steps(3);
        chk("busy_no_block", 32'(o_blk), 32'd0);
        iblk = 1'b1;
        steps(2);
        chk("blocked_inst_block", 32'(o_blk), 32'd1);
        ab = 2'b00; idle = 1'b1; iblk = 1'b0;
        step();

        // lowering threshold mid-stall locks on the next cycle
        ab = 2'b10;
        steps(2);
        thr = 4'd2;
        step();
        chk("thr_lower_irq", 32'(o_irq), 32'd1);
        clr = 1'b1; ab = 2'b00; thr = 4'd4;
        step();
        clr = 1'b0;

        // T5: clear on the exact lock cycle wins, no irq
        ab = 2'b10;
        steps(3);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("t5_no_deadlock", 32'(o_dl), 32'd0);
        chk("t5_no_irq", 32'(o_irq), 32'd0);
        chk("t5_stall_zero", 32'(o_st), 32'd0);
        step();
        chk("t5_monitor_restart", 32'(o_st), 32'd1);
        ab = 2'b00;
        step();

        // T6: async reset while LOCKED, then warmup repeats
        thr = 4'd1; ab = 2'b10;
        steps(2);
        chk("t6_locked", 32'(o_dl), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        push_exp();
        check_pop();
        steps(2);
        rst_n = 1'b1;
        steps(2);
        clr = 1'b1;
        step();
        clr = 1'b0;
        steps(7);
        chk("t6_block_warmup", 32'(o_blk), 32'd0);
        step();
        chk("t6_block_after", 32'(o_blk), 32'd1);
        step();
        chk("t6_irq", 32'(o_irq), 32'd1);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
